// File: rtl/ammo_sat_counter_if.sv
// ammo_sat_counter_if: control/status bundle between the weapons controller
// and the saturating ammunition counter.
//   up, down, load, load_max, in, rate : controller -> counter
//   out, max, empty, full              : counter -> controller
interface ammo_sat_counter_if #(
    parameter int N = 9
);
    logic         up;
    logic         down;
    logic         load;
    logic [1:0]   load_max;
    logic [N-1:0] in;
    logic [N-1:0] rate;
    logic [N-1:0] out;
    logic [N-1:0] max;
    logic         empty;
    logic         full;

    modport master (
        output up, down, load, load_max, in, rate,
        input  out, max, empty, full
    );

    modport slave (
        input  up, down, load, load_max, in, rate,
        output out, max, empty, full
    );
endinterface

// File: rtl/ammo_sat_counter.sv
// ammo_sat_counter: saturating ammo count with programmable ceiling.
// Ports: clk, rst (async active-low), bus (slave: controls in, count/ceiling/flags out).
module ammo_sat_counter #(
    parameter int N = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    ammo_sat_counter_if.slave     bus
);
    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = N'(1);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;
    logic [N-1:0] max_q;
    logic [N-1:0] max_d;
    logic [N-1:0] step_val;

    logic max_ld;
    logic max_hold;
    logic sel_hold;
    logic sel_load;
    logic sel_step;
    logic sel_clr;

    // Ceiling: two-way one-hot mux {hold, load}
    assign max_ld   = (bus.load_max == 2'b01);
    assign max_hold = ~max_ld;
    assign max_d    = ({N{max_hold}} & max_q)
                    | ({N{max_ld}}   & bus.in);

    // Count: four-way one-hot mux {hold, load, step, clear}.
    // Clear covers a decrement that would reach or pass zero.
    assign sel_load = bus.load;
    assign sel_clr  = ~bus.load & bus.down & (count_q <= bus.rate);
    assign sel_step = ~bus.load
                    & ((bus.down & (count_q > bus.rate))
                    |  (~bus.down & bus.up));
    assign sel_hold = ~bus.load & ~bus.down & ~bus.up;

    // Up saturates at the current ceiling, also pulling an
    // over-ceiling count back down to it.
    always_comb begin
        step_val = count_q;
        if (bus.down)
            step_val = count_q - bus.rate;
        else if (count_q < max_q)
            step_val = count_q + ONE;
        else
            step_val = max_q;
    end

    assign count_d = ({N{sel_hold}} & count_q)
                   | ({N{sel_load}} & bus.in)
                   | ({N{sel_step}} & step_val)
                   | ({N{sel_clr}}  & ZERO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            max_q   <= '0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    assign bus.out   = count_q;
    assign bus.max   = max_q;
    assign bus.empty = (count_q == ZERO);
    assign bus.full  = (count_q >= max_q);
endmodule

// File: tb/tb_ammo_sat_counter.sv
// tb_ammo_sat_counter: directed vectors for ammo_sat_counter.
// Drives the controller side of the bus and checks count, ceiling and flags.
module tb_ammo_sat_counter;
    localparam int N = 9;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ammo_sat_counter_if #(.N(N)) bus ();

    ammo_sat_counter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.up       = 1'b0;
        bus.down     = 1'b0;
        bus.load     = 1'b0;
        bus.load_max = 2'b00;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.in      = '0;
        bus.rate    = '0;
        idle();

        // async reset between edges
        tick();
        #2 rst = 1'b0;
        #1;
        check("rst_out", bus.out, 9'd0);
        check("rst_max", bus.max, 9'd0);
        check("rst_empty", 9'(bus.empty), 9'd1);
        check("rst_full", 9'(bus.full), 9'd1);
        tick();
        rst = 1'b1;

        // ceiling and count loaded together
        bus.in = 9'd100; bus.load_max = 2'b01; bus.load = 1'b1;
        tick();
        check("ld_max", bus.max, 9'd100);
        check("ld_out", bus.out, 9'd100);
        check("ld_full", 9'(bus.full), 9'd1);
        check("ld_empty", 9'(bus.empty), 9'd0);

        // only load_max==01 loads the ceiling
        idle(); bus.in = 9'd7; bus.load_max = 2'b10;
        tick();
        check("lm10_hold", bus.max, 9'd100);
        bus.load_max = 2'b11;
        tick();
        check("lm11_hold", bus.max, 9'd100);

        // up saturation at max=5 from out=3
        idle(); bus.in = 9'd5; bus.load_max = 2'b01;
        tick();
        idle(); bus.in = 9'd3; bus.load = 1'b1;
        tick();
        check("sat_pre_out", bus.out, 9'd3);
        check("sat_pre_max", bus.max, 9'd5);
        idle(); bus.up = 1'b1;
        tick(); check("up1", bus.out, 9'd4);
        check("up1_full", 9'(bus.full), 9'd0);
        tick(); check("up2", bus.out, 9'd5);
        check("up2_full", 9'(bus.full), 9'd1);
        tick(); check("up3", bus.out, 9'd5);
        tick(); check("up4", bus.out, 9'd5);

        // lower the ceiling to 2 with up held
        bus.in = 9'd2; bus.load_max = 2'b01;
        tick();
        check("lower_max", bus.max, 9'd2);
        check("lower_out", bus.out, 9'd5);
        bus.load_max = 2'b00;
        tick();
        check("pull_down", bus.out, 9'd2);
        check("pull_full", 9'(bus.full), 9'd1);

        // decrement with clamp at zero
        idle(); bus.in = 9'd10; bus.load = 1'b1;
        tick();
        check("dec_ld", bus.out, 9'd10);
        idle(); bus.rate = 9'd3; bus.down = 1'b1;
        tick(); check("dec1", bus.out, 9'd7);
        tick(); check("dec2", bus.out, 9'd4);
        tick(); check("dec3", bus.out, 9'd1);
        check("dec3_empty", 9'(bus.empty), 9'd0);
        tick(); check("dec4", bus.out, 9'd0);
        check("dec4_empty", 9'(bus.empty), 9'd1);
        tick(); check("dec5", bus.out, 9'd0);

        // rate 0 leaves count unchanged; out==rate clears
        idle(); bus.in = 9'd8; bus.load = 1'b1;
        tick();
        idle(); bus.rate = 9'd0; bus.down = 1'b1;
        tick(); check("rate0", bus.out, 9'd8);
        bus.rate = 9'd8;
        tick(); check("eq_rate", bus.out, 9'd0);

        // hold with nothing asserted
        idle(); bus.in = 9'd9; bus.load = 1'b1;
        tick();
        idle();
        tick(); check("hold", bus.out, 9'd9);

        // priority: load over down over up
        bus.in = 9'd50; bus.load = 1'b1; bus.up = 1'b1; bus.down = 1'b1;
        tick(); check("pri_load", bus.out, 9'd50);
        bus.load = 1'b0; bus.rate = 9'd5;
        tick(); check("pri_down", bus.out, 9'd45);

        // async reset mid-run with down active
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out", bus.out, 9'd0);
        check("mid_rst_max", bus.max, 9'd0);
        tick();
        check("in_rst_out", bus.out, 9'd0);
        idle();
        rst = 1'b1;
        tick(); check("post_rst1", bus.out, 9'd0);
        tick(); check("post_rst2", bus.out, 9'd0);
        check("post_rst_max", bus.max, 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ammo_sat_counter.md
# ammo_sat_counter

Parameterised saturating ammunition counter for the weapons subsystem, built from the shared DFF, Mux2 and Mux4 primitives. It holds a programmable ceiling (`max`) and a current count. The count can be loaded, incremented by one up to the ceiling, or decremented by a programmable rate down to zero. The weapons controller drives it once per clock and reads the count back as the remaining ammunition.

## Interface
- `N`, default 9: width of the count, ceiling, load value and rate.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low; clears count and ceiling.
- `up`  in  1: increment request.
- `down`  in  1: decrement (fire) request.
- `load`  in  1: load the count from `in`.
- `load_max`  in  2: ceiling register control; `2'b01` loads the ceiling from `in`, any other value holds it.
- `in`  in  N: load value for the count and/or the ceiling.
- `rate`  in  N: decrement step.
- `out`  out  N: current count (registered).
- `max`  out  N: current ceiling (registered).
- `empty`  out  1: `out == 0` (combinational from registers).
- `full`  out  1: `out >= max` (combinational from registers).

## Operation
- Ceiling register: next value is `in` when `load_max == 2'b01`, otherwise it holds. It is independent of the count controls.
- Count next-state, priority order:
  1. `rst` low: count 0 (asynchronous).
  2. `load`: count = `in`. `in` is not clamped to `max`.
  3. `down`: if `out > rate`, count = `out - rate`; otherwise 0. No wrap-around ever occurs.
  4. `up` (only when `down` is low): if `out < max`, count = `out + 1`; otherwise count = `max`. A count above a newly lowered ceiling is pulled down to the ceiling.
  5. None of `load`, `up`, `down` asserted: hold.
- `up` and `down` together: `down` wins.
- `rate == 0` with `down`: count unchanged.
- Arithmetic is unsigned, N bits. The comparisons use the registered `max` from the current cycle, not a ceiling being loaded in the same edge.
- Structure:
  - The ceiling uses Mux2 (one-hot select `{hold, load}`) feeding an N-bit DFF.
  - The count uses Mux4 (one-hot select `{hold, load, up|down, reset}`) feeding an N-bit DFF.
  - The Mux4 selects are one-hot by construction.

## Timing
- Reset: `out` = 0 and `max` = 0 immediately on `rst` falling, independent of `clk`. `empty` = 1 and `full` = 1 while both registers are 0.
- Deassertion of `rst` is synchronised by the system; the first update occurs on the first rising edge with `rst` high.
- Latency: one cycle from a control input sampled at the edge to `out`/`max` valid after that edge. `empty`/`full` follow in the same cycle.
- `rst` asserted mid-operation discards any pending load or update. The count and ceiling stay 0 until `rst` is released and new loads arrive.
- `load` and `load_max == 2'b01` in the same cycle: both registers take `in` on the same edge.

## Test plan
- Reset: drive `rst` low between edges → `out`=0, `max`=0, `empty`=1 immediately, before the next edge.
- Ceiling and load: with `in`=100, `load_max`=01 and `load`=1 for one edge → `max`=100, `out`=100, `full`=1.
- Up saturation: `max`=5, `out`=3, `up` held 4 cycles → `out` sequence 4, 5, 5, 5. With `max` then reloaded to 2 and `up` held → `out`=2 next cycle.
- Decrement with clamp: `out`=10, `rate`=3, `down` held → 7, 4, 1, 0, 0. `empty` asserts at 0 and the count never wraps to 511.
- Priority: `load`=1 (`in`=50) with `up`=1 and `down`=1 → `out`=50. Then `up`=1 and `down`=1 with `rate`=5 → `out`=45.
- Async reset mid-run: count at 45 with `down` active; pulse `rst` low off-edge → `out`=0 at once. After release with no inputs asserted, `out` holds 0.
